// File: rtl/seq_detect_param_if.sv
// Bus bundle for the serial pattern detector: qualified data input,
// pattern load/clear controls and the detector status outputs.
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             match;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;
  logic [PAT_W-1:0] pattern;

  modport master (
    output en, x, pat_load, pat_in, cnt_clr,
    input  match, armed, match_cnt, pattern
  );

  modport slave (
    input  en, x, pat_load, pat_in, cnt_clr,
    output match, armed, match_cnt, pattern
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector. Shifts qualified bits into a
// history register (newest bit in the LSB) and raises a registered
// one-cycle match pulse whenever the last PAT_W bits equal the active
// pattern. A saturating counter tallies matches.
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1110,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  typedef enum logic {
    FILL = 1'b0,
    HUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;

  logic [PAT_W-1:0] hist_n;
  logic [FW-1:0]    fill_n;
  logic             hit;
  logic             unused_hist_msb;

  // The oldest history bit falls off the end of the shift and is never compared.
  assign unused_hist_msb = hist_q[PAT_W-1];

  // Candidate history/fill for a qualified bit, and whether it completes the pattern.
  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], bus.x};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
    hit    = (fill_n == FILL_FULL) && (hist_n == pat_q);
  end

  // Next-state logic: load beats a qualified bit; counter clear beats an increment.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;

    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (bus.en) begin
      if (hit) begin
        match_d = 1'b1;
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (OVERLAP) begin
          hist_d  = hist_n;
          fill_d  = FILL_FULL;
          state_d = HUNT;
        end else begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = FILL;
        end
      end else begin
        hist_d  = hist_n;
        fill_d  = fill_n;
        state_d = (fill_n == FILL_FULL) ? HUNT : FILL;
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_RST;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign bus.match     = match_q;
  assign bus.armed     = (state_q == HUNT);
  assign bus.match_cnt = cnt_q;
  assign bus.pattern   = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param. Three detectors share one stimulus stream:
//   dut0: 4-bit pattern, overlapping matches, 8-bit counter
//   dut1: 4-bit pattern, non-overlapping matches, 8-bit counter
//   dut2: 2-bit pattern "11", overlapping matches, 2-bit counter
// A reference model tracks, per detector, the qualified bits seen since the
// last flush and the active pattern, and predicts every output after each edge.
module tb_seq_detect_param;

  logic clk;
  logic rst;

  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if0 ();
  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if1 ();
  seq_detect_param_if #(.PAT_W(2), .CNT_W(2)) if2 ();

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1110), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1110), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  seq_detect_param #(.PAT_W(2), .PAT_RST(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  int total = 0;
  int bad   = 0;

  // Per-detector configuration for the model.
  int unsigned pw[3]   = '{4, 4, 2};
  bit          ov[3]   = '{1'b1, 1'b0, 1'b1};
  int unsigned cmax[3] = '{255, 255, 3};
  int unsigned prst[3] = '{14, 14, 3};

  // Model state: last pw qualified bits, how many bits seen since flush,
  // active pattern, match count, and the predicted outputs.
  int unsigned m_last[3];
  int unsigned m_seen[3];
  int unsigned m_pat[3];
  int unsigned m_cnt[3];
  bit          m_match[3];
  bit          m_armed[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the reference model by one clock edge with the given inputs.
  task automatic modelStep(input bit r, input bit e, input bit xx, input bit ld,
                           input logic [31:0] pin, input bit clr);
    for (int i = 0; i < 3; i++) begin
      int unsigned mask;
      mask = (32'd1 << pw[i]) - 1;
      if (!r) begin
        m_last[i]  = 0;
        m_seen[i]  = 0;
        m_pat[i]   = prst[i];
        m_cnt[i]   = 0;
        m_match[i] = 1'b0;
      end else begin
        m_match[i] = 1'b0;
        if (ld) begin
          m_pat[i]  = pin & mask;
          m_last[i] = 0;
          m_seen[i] = 0;
        end else if (e) begin
          m_last[i] = ((m_last[i] * 2) + (xx ? 1 : 0)) & mask;
          if (m_seen[i] < pw[i]) m_seen[i] = m_seen[i] + 1;
          if (m_seen[i] >= pw[i] && m_last[i] == m_pat[i]) begin
            m_match[i] = 1'b1;
            if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            if (!ov[i]) begin
              m_last[i] = 0;
              m_seen[i] = 0;
            end
          end
        end
        if (clr) m_cnt[i] = 0;
      end
      m_armed[i] = (m_seen[i] >= pw[i]);
    end
  endtask

  // One counted comparison.
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every detector's outputs against the model.
  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] om, oa, oc, op;
      case (i)
        0: begin
          om = 32'(if0.match); oa = 32'(if0.armed);
          oc = 32'(if0.match_cnt); op = 32'(if0.pattern);
        end
        1: begin
          om = 32'(if1.match); oa = 32'(if1.armed);
          oc = 32'(if1.match_cnt); op = 32'(if1.pattern);
        end
        default: begin
          om = 32'(if2.match); oa = 32'(if2.armed);
          oc = 32'(if2.match_cnt); op = 32'(if2.pattern);
        end
      endcase
      checkVal($sformatf("match%0d", i), om, 32'(m_match[i]));
      checkVal($sformatf("armed%0d", i), oa, 32'(m_armed[i]));
      checkVal($sformatf("cnt%0d", i), oc, m_cnt[i]);
      checkVal($sformatf("pattern%0d", i), op, m_pat[i]);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, then check.
  task automatic applyStimulus(input bit r, input bit e, input bit xx, input bit ld,
                               input logic [31:0] pin, input bit clr);
    rst          = r;
    if0.en       = e;  if1.en       = e;  if2.en       = e;
    if0.x        = xx; if1.x        = xx; if2.x        = xx;
    if0.pat_load = ld; if1.pat_load = ld; if2.pat_load = ld;
    if0.pat_in   = pin[3:0]; if1.pat_in = pin[3:0]; if2.pat_in = pin[1:0];
    if0.cnt_clr  = clr; if1.cnt_clr = clr; if2.cnt_clr = clr;
    @(posedge clk);
    modelStep(r, e, xx, ld, pin, clr);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [31:0] pin;
    bit r, e, xx, ld, clr;

    rst = 1'b0;
    if0.en = 0; if1.en = 0; if2.en = 0;
    if0.x = 0; if1.x = 0; if2.x = 0;
    if0.pat_load = 0; if1.pat_load = 0; if2.pat_load = 0;
    if0.pat_in = 0; if1.pat_in = 0; if2.pat_in = 0;
    if0.cnt_clr = 0; if1.cnt_clr = 0; if2.cnt_clr = 0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("rst_pattern0", 32'(if0.pattern), 32'he);
    checkVal("rst_pattern2", 32'(if2.pattern), 32'h3);
    checkVal("rst_cnt0", 32'(if0.match_cnt), 0);
    checkVal("rst_armed0", 32'(if0.armed), 0);

    // Default pattern 1110: match only after the 4th bit
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkVal("p1110_before", 32'(if0.match), 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkVal("p1110_match", 32'(if0.match), 1);
    checkVal("p1110_cnt", 32'(if0.match_cnt), 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkVal("p1110_after", 32'(if0.match), 0);

    // Pattern 1010: overlapping vs non-overlapping
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 32'ha, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkVal("p1010_m4_ov", 32'(if0.match), 1);
    checkVal("p1010_m4_nov", 32'(if1.match), 1);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkVal("p1010_m6_ov", 32'(if0.match), 1);
    checkVal("p1010_m6_nov", 32'(if1.match), 0);
    checkVal("p1010_cnt_ov", 32'(if0.match_cnt), 2);
    checkVal("p1010_cnt_nov", 32'(if1.match_cnt), 1);

    // Unqualified cycles do not break a partial sequence
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 1'($urandom), 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkVal("gap_armed3", 32'(if0.armed), 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkVal("gap_armed4", 32'(if0.armed), 1);
    checkVal("gap_match", 32'(if0.match), 1);
    checkVal("gap_cnt", 32'(if0.match_cnt), 1);

    // Mid-sequence reset and pattern load discard history
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkVal("midrst_match", 32'(if0.match), 0);
    checkVal("midrst_cnt", 32'(if0.match_cnt), 0);
    applyStimulus(1, 1, 1, 1, 32'h6, 0);
    checkVal("load_pattern", 32'(if0.pattern), 32'h6);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkVal("load_match", 32'(if0.match), 1);
    checkVal("load_cnt", 32'(if0.match_cnt), 1);

    // Saturation on the 2-bit counter with pattern 11
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkVal("sat_first", 32'(if2.match), 0);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, 1, 1, 0, 0, 0);
      checkVal($sformatf("sat_pulse%0d", k), 32'(if2.match), 1);
    end
    checkVal("sat_cnt", 32'(if2.match_cnt), 3);
    applyStimulus(1, 1, 1, 0, 0, 1);
    checkVal("clr_match", 32'(if2.match), 1);
    checkVal("clr_cnt", 32'(if2.match_cnt), 0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r   = ($urandom_range(63) != 0);
      ld  = ($urandom_range(31) == 0);
      e   = ($urandom_range(3) != 0);
      clr = ($urandom_range(31) == 0);
      xx  = 1'($urandom);
      pin = $urandom;
      applyStimulus(r, e, xx, ld, pin, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
